note_sequencer: RTL and testbench



---
 rtl/note_pkg.sv | 77 +++++++
 rtl/note_sequencer_tick_prescaler.sv | 29 ++
 rtl/note_sequencer.sv | 167 ++++++++++++++++
 tb/tb_note_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer: note entry format, FSM states,
// the pitch frequency table, the elaboration-time half-period helper and the default song.
// Latency: n/a (constants only). Backpressure: n/a.
package note_pkg;

    // One song entry: pitch 0 is a rest, 63 ends the song, 1..48 are C3..B6.
    // Length of the entry is (dur+1) eighth notes.
    typedef struct packed {
        logic [5:0] pitch;
        logic [2:0] dur;
    } note_t;

    localparam logic [5:0] PITCH_REST = 6'd0;
    localparam logic [5:0] PITCH_END  = 6'd63;

    localparam int unsigned NUM_PITCHES = 48;
    localparam int unsigned SONG_MAX    = 32;

    // Equal-tempered frequencies rounded to whole Hz, C3 first.
    localparam int unsigned FREQ_HZ [NUM_PITCHES] = '{
         131,  139,  147,  156,  165,  175,  185,  196,  208,  220,  233,  247,
         262,  277,  294,  311,  330,  349,  370,  392,  415,  440,  466,  494,
         523,  554,  587,  622,  659,  698,  740,  784,  831,  880,  932,  988,
        1047, 1109, 1175, 1245, 1319, 1397, 1480, 1568, 1661, 1760, 1865, 1976
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SOUND,
        GAP,
        END
    } state_t;

    // Half period in clk cycles, rounded down. Rests and markers give 0.
    // Only ever called with constant arguments so it folds at elaboration.
    function automatic logic [19:0] half_period(input int unsigned clk_hz, input logic [5:0] pitch);
        logic [19:0] hp;
        hp = '0;
        if (pitch >= 6'd1 && pitch <= 6'd48) begin
            hp = 20'(clk_hz / (2 * FREQ_HZ[pitch - 6'd1]));
        end
        return hp;
    endfunction

    function automatic note_t nt(input logic [5:0] pitch, input logic [2:0] dur);
        note_t n;
        n.pitch = pitch;
        n.dur   = dur;
        return n;
    endfunction

    localparam logic [5:0] P_C4 = 6'd13;
    localparam logic [5:0] P_D4 = 6'd15;
    localparam logic [5:0] P_E4 = 6'd17;
    localparam logic [5:0] P_F4 = 6'd18;
    localparam logic [5:0] P_G4 = 6'd20;

    localparam logic [2:0] D_EIGHTH  = 3'd0;
    localparam logic [2:0] D_QUARTER = 3'd1;
    localparam logic [2:0] D_DOTTED  = 3'd2;
    localparam logic [2:0] D_HALF    = 3'd3;

    // Default melody (two phrases of Ode to Joy), index 0 leftmost.
    localparam note_t [0:SONG_MAX-1] SONG = {
        nt(P_E4, D_QUARTER), nt(P_E4, D_QUARTER), nt(P_F4, D_QUARTER), nt(P_G4, D_QUARTER),
        nt(P_G4, D_QUARTER), nt(P_F4, D_QUARTER), nt(P_E4, D_QUARTER), nt(P_D4, D_QUARTER),
        nt(P_C4, D_QUARTER), nt(P_C4, D_QUARTER), nt(P_D4, D_QUARTER), nt(P_E4, D_QUARTER),
        nt(P_E4, D_DOTTED),  nt(P_D4, D_EIGHTH),  nt(P_D4, D_HALF),
        nt(P_E4, D_QUARTER), nt(P_E4, D_QUARTER), nt(P_F4, D_QUARTER), nt(P_G4, D_QUARTER),
        nt(P_G4, D_QUARTER), nt(P_F4, D_QUARTER), nt(P_E4, D_QUARTER), nt(P_D4, D_QUARTER),
        nt(P_C4, D_QUARTER), nt(P_C4, D_QUARTER), nt(P_D4, D_QUARTER), nt(P_E4, D_QUARTER),
        nt(P_D4, D_DOTTED),  nt(P_C4, D_EIGHTH),  nt(P_C4, D_HALF),
        nt(PITCH_REST, D_QUARTER), nt(PITCH_END, D_EIGHTH)
    };

endpackage

// File: rtl/note_sequencer_tick_prescaler.sv
// Tick prescaler: one-cycle tick every DIV clocks; clr restarts the count so the next tick lands DIV clocks later.
// Latency: tick is combinational from the count register. Backpressure: none, free-running.
// Ports: clk, reset (sync, active-high), clr (restart count), tick (one-cycle pulse).
module tick_prescaler #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = wrap && !clr;

    always_ff @(posedge clk) begin
        if (reset || clr || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks the note table, drives half-period + tone enable for each note then a silent gap.
// Latency: play at cycle N -> LOAD at N+1 -> tone_en at N+2. Backpressure: none; stop aborts, play while busy is ignored.
// Ports: clk, reset (sync, active-high), play/stop pulses, loop level; tone_period, tone_en, note_idx, busy, done.
module note_sequencer
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned EIGHTH_TICKS = 125,
    parameter int unsigned GAP_TICKS    = 20,
    parameter int unsigned SONG_LEN     = 32,
    parameter note_t [0:SONG_MAX-1] SONG_TBL = SONG
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        play,
    input  logic                        stop,
    input  logic                        loop,
    output logic [19:0]                 tone_period,
    output logic                        tone_en,
    output logic [$clog2(SONG_LEN)-1:0] note_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned IW    = $clog2(SONG_LEN);
    localparam int unsigned SEL_W = $clog2(SONG_MAX);
    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;

    if (SONG_LEN < 2 || SONG_LEN > SONG_MAX) begin : g_bad_len
        $error("note_sequencer: SONG_LEN must be 2..%0d", SONG_MAX);
    end
    if (GAP_TICKS < 1 || GAP_TICKS >= EIGHTH_TICKS) begin : g_bad_gap
        $error("note_sequencer: GAP_TICKS must be 1..EIGHTH_TICKS-1");
    end
    if (8 * EIGHTH_TICKS > 4095) begin : g_bad_tempo
        $error("note_sequencer: longest note overflows the 12-bit tick counter");
    end
    if (DIV < 1) begin : g_bad_tick
        $error("note_sequencer: TICK_HZ must not exceed CLK_HZ");
    end
    if (CLK_HZ / (2 * FREQ_HZ[0]) >= 2**20) begin : g_bad_clk
        $error("note_sequencer: CLK_HZ too large, C3 half period exceeds 20 bits");
    end

    // Half-period ROM, folded to constants at elaboration.
    logic [19:0] hp_tbl [64];
    for (genvar p = 0; p < 64; p++) begin : g_hp
        assign hp_tbl[p] = half_period(CLK_HZ, 6'(p));
    end

    state_t          state_q;
    logic [19:0]     tone_period_q;
    logic            tone_en_q;
    logic [IW-1:0]   note_idx_q;
    logic            busy_q;
    logic [11:0]     cnt_q;
    logic [2:0]      dur_q;

    logic            tick;
    note_t           entry;
    logic [11:0]     cnt_inc;
    logic [11:0]     sound_tgt;
    logic            last_entry;

    tick_prescaler #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == LOAD),
        .tick  (tick)
    );

    assign entry      = SONG_TBL[SEL_W'(note_idx_q)];
    assign cnt_inc    = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
    // Audible part of the note; the gap is carved out of the note length.
    assign sound_tgt  = 12'((32'(dur_q) + 32'd1) * EIGHTH_TICKS - GAP_TICKS);
    assign last_entry = (note_idx_q == IW'(SONG_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tone_period_q <= '0;
            tone_en_q     <= 1'b0;
            note_idx_q    <= '0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            dur_q         <= '0;
        end else if (stop && state_q != IDLE) begin
            state_q    <= IDLE;
            tone_en_q  <= 1'b0;
            note_idx_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A simultaneous stop cancels the start.
                    if (play && !stop) begin
                        state_q    <= LOAD;
                        note_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (entry.pitch == PITCH_END) begin
                        state_q <= END;
                    end else begin
                        state_q       <= SOUND;
                        tone_period_q <= hp_tbl[entry.pitch];
                        tone_en_q     <= (entry.pitch != PITCH_REST);
                        dur_q         <= entry.dur;
                        cnt_q         <= '0;
                    end
                end
                SOUND: begin
                    if (tick) begin
                        if (cnt_inc >= sound_tgt) begin
                            state_q   <= GAP;
                            tone_en_q <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_inc >= 12'(GAP_TICKS)) begin
                            cnt_q <= '0;
                            if (last_entry) begin
                                state_q <= END;
                            end else begin
                                note_idx_q <= note_idx_q + IW'(1);
                                state_q    <= LOAD;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                END: begin
                    if (loop) begin
                        note_idx_q <= '0;
                        state_q    <= LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tone_period = tone_period_q;
    assign tone_en     = tone_en_q;
    assign note_idx    = note_idx_q;
    assign busy        = busy_q;
    // done marks the single END cycle that will drop to IDLE; loop is a
    // synchronised level, so the decode is clean and lets loop be judged in END itself.
    assign done        = (state_q == END) && !loop && !stop;

endmodule

// File: tb/tb_note_sequencer.sv
`timescale 1ns/1ps
module tb_note_sequencer;
    import note_pkg::*;

    localparam int unsigned CLK_HZ = 10_000;
    localparam int unsigned TICK_HZ = 1000;
    localparam int unsigned EIGHTH = 4;
    localparam int unsigned GAP    = 1;
    localparam int unsigned LEN    = 4;
    localparam int unsigned DIV    = CLK_HZ / TICK_HZ;

    // A4 dur0, rest dur1, C5 dur0, END, padded with END markers.
    localparam note_t [0:SONG_MAX-1] TB_SONG = {6'd22, 3'd0, 6'd0, 3'd1, 6'd25, 3'd0, {29{6'd63, 3'd0}}};

    // Reference view of the same song: pitch code, eighths, frequency in Hz.
    localparam int M_PITCH [LEN] = '{22, 0, 25, 63};
    localparam int M_DUR   [LEN] = '{0, 1, 0, 0};
    localparam int M_FREQ  [LEN] = '{440, 0, 523, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [19:0] tone_period;
    logic        tone_en;
    logic [1:0]  note_idx;
    logic        busy;
    logic        done;

    note_sequencer #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .EIGHTH_TICKS (EIGHTH),
        .GAP_TICKS    (GAP),
        .SONG_LEN     (LEN),
        .SONG_TBL     (TB_SONG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .stop        (stop),
        .loop        (loop),
        .tone_period (tone_period),
        .tone_en     (tone_en),
        .note_idx    (note_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases measured in whole clock cycles.
    // 0 idle, 1 load, 2 sounding, 3 gap, 4 end.
    int m_ph = 0;
    int m_left = 0;
    int m_idx = 0;
    int m_known = 1;
    int m_ten = 0;
    int m_per = 0;
    int m_valid = 0;

    function automatic void model_step();
        if (reset) begin
            m_ph = 0; m_idx = 0; m_known = 1; m_ten = 0; m_per = 0;
        end else if (m_ph != 0 && stop) begin
            m_ph = 0; m_idx = 0; m_known = 1; m_ten = 0;
        end else begin
            case (m_ph)
                0: if (play && !stop) begin m_ph = 1; m_idx = 0; m_known = 1; end
                1: begin
                    if (M_PITCH[m_idx] == 63) begin
                        m_ph = 4;
                    end else begin
                        m_ph   = 2;
                        m_left = ((M_DUR[m_idx] + 1) * EIGHTH - GAP) * DIV;
                        m_ten  = (M_PITCH[m_idx] != 0);
                        m_per  = (M_FREQ[m_idx] != 0) ? CLK_HZ / (2 * M_FREQ[m_idx]) : 0;
                    end
                end
                2: if (m_left == 1) begin m_ph = 3; m_left = GAP * DIV; m_ten = 0; end
                   else m_left--;
                3: if (m_left == 1) begin
                       if (m_idx == LEN - 1) m_ph = 4;
                       else begin m_idx++; m_ph = 1; end
                   end else m_left--;
                4: if (loop) begin m_idx = 0; m_ph = 1; end
                   else begin m_ph = 0; m_known = 0; end
                default: m_ph = 0;
            endcase
        end
    endfunction

    task automatic model_compare();
        chk("busy", busy, (m_ph != 0));
        chk("tone_en", tone_en, m_ten);
        chk("done", done, (m_ph == 4 && !loop && !stop));
        if (m_known != 0) chk("note_idx", note_idx, m_idx);
        if (m_ten != 0) chk("tone_period", tone_period, m_per);
    endtask

    // Drive one cycle of inputs, check the model just before the edge, then advance the model.
    task automatic step(input logic r, input logic p, input logic s, input logic l);
        @(negedge clk);
        reset = r; play = p; stop = s; loop = l;
        #3;
        if (m_valid != 0) model_compare();
        @(posedge clk);
        model_step();
        m_valid = 1;
    endtask

    typedef struct {
        int adv; int play; int stop; int loop;
        int busy; int ten; int chk_per; int per; int idx; int done;
    } vec_t;

    vec_t vt [14];

    initial begin
        logic l;

        // adv, play, stop, loop, busy, tone_en, chk_per, per, idx(-1 = skip), done
        vt[0]  = '{1,  1, 0, 0, 1, 0, 0, 0,  0, 0};
        vt[1]  = '{1,  0, 0, 0, 1, 1, 1, 11, 0, 0};
        vt[2]  = '{29, 0, 0, 0, 1, 1, 1, 11, 0, 0};
        vt[3]  = '{1,  0, 0, 0, 1, 0, 0, 0,  0, 0};
        vt[4]  = '{9,  0, 0, 0, 1, 0, 0, 0,  0, 0};
        vt[5]  = '{1,  0, 0, 0, 1, 0, 0, 0,  1, 0};
        vt[6]  = '{1,  0, 0, 0, 1, 0, 0, 0,  1, 0};
        vt[7]  = '{40, 1, 0, 0, 1, 0, 0, 0,  1, 0};
        vt[8]  = '{39, 0, 0, 0, 1, 0, 0, 0,  1, 0};
        vt[9]  = '{1,  0, 0, 0, 1, 0, 0, 0,  2, 0};
        vt[10] = '{1,  0, 0, 0, 1, 1, 1, 9,  2, 0};
        vt[11] = '{40, 0, 0, 0, 1, 0, 0, 0,  3, 0};
        vt[12] = '{1,  0, 0, 0, 1, 0, 0, 0,  3, 1};
        vt[13] = '{1,  0, 0, 0, 0, 0, 0, 0, -1, 0};

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_tone_en", tone_en, 0);
        chk("rst_period", tone_period, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_done", done, 0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full non-looping song, with a play pulse injected mid-rest.
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < vt[i].adv; k++) begin
                step(1'b0, (k == 0) ? vt[i].play[0] : 1'b0, (k == 0) ? vt[i].stop[0] : 1'b0, vt[i].loop[0]);
            end
            #1;
            chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("v%0d_tone_en", i), tone_en, vt[i].ten);
            chk($sformatf("v%0d_done", i), done, vt[i].done);
            if (vt[i].chk_per != 0) chk($sformatf("v%0d_period", i), tone_period, vt[i].per);
            if (vt[i].idx >= 0) chk($sformatf("v%0d_idx", i), note_idx, vt[i].idx);
        end

        // Looping: END must not raise done and must restart at entry 0.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (164) step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("loop_end_done", done, 0);
        chk("loop_end_busy", busy, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("loop_restart_idx", note_idx, 0);
        chk("loop_restart_busy", busy, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("loop_restart_tone", tone_en, 1);
        chk("loop_restart_period", tone_period, 11);

        // Stop while entry 2 sounds.
        repeat (129) step(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_stop_idx", note_idx, 2);
        chk("pre_stop_tone", tone_en, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("stop_tone", tone_en, 0);
        chk("stop_busy", busy, 0);
        chk("stop_idx", note_idx, 0);
        chk("stop_done", done, 0);

        // play and stop together from IDLE: nothing starts.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("playstop_busy", busy, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("playstop_busy2", busy, 0);

        // Reset in the middle of the first gap.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (35) step(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("gap_tone", tone_en, 0);
        chk("gap_busy", busy, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_tone", tone_en, 0);
        chk("midrst_period", tone_period, 0);
        chk("midrst_idx", note_idx, 0);
        chk("midrst_done", done, 0);

        // Random control traffic against the model.
        l = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) l = ~l;
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 149) == 0), l);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
